// File: rtl/dice_pkg.sv
// Shared widths, die limits and the die step function for the dice roller
// and the controller's tests.
package dice_pkg;

    localparam int DIE_W = 3;
    localparam int SUM_W = 4;

    localparam logic [DIE_W-1:0] DIE_MIN = 3'd1;
    localparam logic [DIE_W-1:0] DIE_MAX = 3'd6;

    function automatic logic [DIE_W-1:0] die_next(input logic [DIE_W-1:0] v);
        return (v == DIE_MAX) ? DIE_MIN : v + 1'b1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus disagreement counter that produces a clean
// button level. Reusable for any slow push-button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic rb
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             btn_s;
    logic [CNT_W-1:0] cnt;

    // The toggle fires on the edge where the count would reach DEBOUNCE_CYCLES,
    // giving 2 + DEBOUNCE_CYCLES edges from a clean btn_raw step to rb.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
            cnt   <= '0;
            rb    <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            btn_s <= sync1;
            if (btn_s == rb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
                rb  <= ~rb;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dice_roller.sv
// Debounced roll button, two free-spinning dice frozen when roll drops,
// their combinational sum and a saturating completed-roll counter.
module dice_roller
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_raw,
    input  logic               roll,
    output logic               rb,
    output logic [DIE_W-1:0]   die1,
    output logic [DIE_W-1:0]   die2,
    output logic [SUM_W-1:0]   sum,
    output logic               sum_valid,
    output logic [COUNT_W-1:0] roll_count
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic roll_d;
    logic roll_done;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_raw),
        .rb     (rb)
    );

    assign roll_done = ~roll & roll_d;

    // die2 advances only when die1 wraps, so the pair walks all 36 outcomes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            die1 <= DIE_MIN;
            die2 <= DIE_MIN;
        end else if (roll) begin
            die1 <= die_next(die1);
            if (die1 == DIE_MAX) begin
                die2 <= die_next(die2);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            roll_d     <= 1'b0;
            sum_valid  <= 1'b0;
            roll_count <= '0;
        end else begin
            roll_d <= roll;
            if (roll) begin
                sum_valid <= 1'b0;
            end else if (roll_done) begin
                sum_valid <= 1'b1;
                if (roll_count != COUNT_MAX) begin
                    roll_count <= roll_count + 1'b1;
                end
            end
        end
    end

    // Purely combinational so the controller can use sum in the cycle roll drops.
    assign sum = {1'b0, die1} + {1'b0, die2};

    die_range_a : assert property (@(posedge clk) disable iff (reset)
        (die1 >= DIE_MIN) && (die1 <= DIE_MAX) && (die2 >= DIE_MIN) && (die2 <= DIE_MAX));

endmodule
